// File: rtl/lab7_soc_key_pio_in.sv
// Avalon-MM input PIO: synchronizes, debounces and edge-captures key lines, with a masked level IRQ.
// Optional KEY_PIO_BIT_CLEAR_EN: writes to edge_capture clear only the bits set in writedata.

module lab7_soc_key_pio_in_lane #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    // One extra counter bit so the count can never wrap before the accept compare.
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= IDLE_BIT;
            s2     <= IDLE_BIT;
            stable <= IDLE_BIT;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module lab7_soc_key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int IDLE_LEVEL      = 1,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic             IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};

    logic [WIDTH-1:0] stable, stable_d, edge_hit, cap, cap_keep, mask;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr           = chipselect && !write_n;

    lab7_soc_key_pio_in_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IDLE_BIT       (IDLE_BIT)
    ) u_lane [WIDTH-1:0] (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (in_port),
        .stable (stable)
    );

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = stable & ~stable_d;
            1:       edge_hit = ~stable & stable_d;
            default: edge_hit = stable ^ stable_d;
        endcase
    end

    // A clearing write and a fresh edge in the same cycle: the edge wins.
    always_comb begin
        cap_keep = cap;
        if (wr && address == 2'd3) begin
`ifdef KEY_PIO_BIT_CLEAR_EN
            cap_keep = cap & ~writedata[WIDTH-1:0];
`else
            cap_keep = '0;
`endif
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd2:    rd_next[WIDTH-1:0] = mask;
            2'd3:    rd_next[WIDTH-1:0] = cap;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= IDLE_VEC;
            cap      <= '0;
            mask     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            cap      <= cap_keep | edge_hit;
            if (wr && address == 2'd2) mask <= writedata[WIDTH-1:0];
            readdata <= rd_next;
            irq      <= |(cap & mask);
        end
    end
endmodule

// File: tb/tb_lab7_soc_key_pio_in.sv
// Randomized and directed bench for lab7_soc_key_pio_in against a cycle-level behavioural model.
module tb_lab7_soc_key_pio_in;
    localparam int W = 4;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '1;
    logic [31:0]  readdata;
    logic         irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lab7_soc_key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .IDLE_LEVEL(1), .EDGE_TYPE(1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // Reference: a level is accepted once the twice-delayed input has disagreed with the
    // accepted level for D consecutive cycles; falling accepted levels raise sticky flags.
    logic [W-1:0] m_d1, m_d2, m_lvl, m_old, m_flag, m_mask;
    logic [W-1:0] n_lvl, n_flag, n_mask, n_fall;
    int           m_run [W];
    int           n_run [W];
    logic [31:0]  m_rd, n_rd;
    logic         m_irq, n_irq;
    logic         m_wr;

    always_comb begin
        m_wr   = chipselect && !write_n;
        n_fall = m_old & ~m_lvl;
        n_flag = m_flag;
        if (m_wr && address == 2'd3) begin
`ifdef KEY_PIO_BIT_CLEAR_EN
            n_flag = m_flag & ~writedata[W-1:0];
`else
            n_flag = '0;
`endif
        end
        n_flag = n_flag | n_fall;
        n_mask = (m_wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
        n_irq  = (m_flag & m_mask) != 0;
        n_rd   = 32'd0;
        if (address == 2'd0) n_rd = {28'd0, m_lvl};
        if (address == 2'd2) n_rd = {28'd0, m_mask};
        if (address == 2'd3) n_rd = {28'd0, m_flag};
        n_lvl = m_lvl;
        for (int b = 0; b < W; b++) begin
            n_run[b] = (m_d2[b] != m_lvl[b]) ? m_run[b] + 1 : 0;
            if (n_run[b] == D) begin
                n_lvl[b] = m_d2[b];
                n_run[b] = 0;
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d1 <= '1; m_d2 <= '1; m_lvl <= '1; m_old <= '1;
            m_flag <= '0; m_mask <= '0; m_rd <= '0; m_irq <= 1'b0;
            for (int b = 0; b < W; b++) m_run[b] <= 0;
        end else begin
            m_d1 <= in_port; m_d2 <= m_d1; m_old <= m_lvl; m_lvl <= n_lvl;
            m_flag <= n_flag; m_mask <= n_mask; m_rd <= n_rd; m_irq <= n_irq;
            for (int b = 0; b < W; b++) m_run[b] <= n_run[b];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 4'hF;
        repeat (3) tick();
        n_tests++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: readdata=%h irq=%b, want 0/0", readdata, irq);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            address = (i % 2 == 1) ? 2'd3 : 2'd0;
            tick();
            n_tests++;
            if (readdata !== ((i % 2 == 1) ? 32'd0 : 32'hF) || irq !== 1'b0) begin
                n_fail++; $display("FAIL reset_idle[%0d]: readdata=%h irq=%b", i, readdata, irq);
            end
        end
    endtask

    task automatic test_fall_latency();
        address = 2'd0;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            n_tests++;
            if (readdata !== ((k >= D + 3) ? 32'hE : 32'hF) || irq !== 1'b0) begin
                n_fail++; $display("FAIL fall_latency[k=%0d]: readdata=%h irq=%b", k, readdata, irq);
            end
        end
        address = 2'd3;
        tick(); tick();
        n_tests++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_fail++; $display("FAIL fall_flag: readdata=%h want 1 (model %h)", readdata, m_rd);
        end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'hFFFF_FFF1);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_pre: irq=%b want 0", irq); end
        tick();
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b want 1", irq); end
        address = 2'd2; tick(); tick();
        n_tests++;
        if (readdata !== 32'h1) begin n_fail++; $display("FAIL mask_read: readdata=%h want 1", readdata); end
        bus_write(2'd3, 32'd0);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: irq=%b want 1", irq); end
        tick();
        n_tests++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            n_fail++; $display("FAIL irq_fall: irq=%b readdata=%h want 0/0", irq, readdata);
        end
    endtask

    task automatic test_glitch();
        address = 2'd0;
        in_port[1] = 1'b0;
        repeat (10) tick();
        in_port[1] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_tests++;
            if (readdata !== 32'hE || irq !== 1'b0) begin
                n_fail++; $display("FAIL glitch[%0d]: readdata=%h irq=%b want E/0", k, readdata, irq);
            end
        end
        address = 2'd3; tick();
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL glitch_flag: readdata=%h want 0", readdata); end
    endtask

    task automatic test_edge_vs_clear();
        in_port[3] = 1'b0;
        address = 2'd3;
        repeat (25) tick();
        n_tests++;
        if (readdata !== 32'h8) begin n_fail++; $display("FAIL pre_collision: readdata=%h want 8", readdata); end
        in_port[2] = 1'b0;
        repeat (D + 2) tick();
        bus_write(2'd3, 32'd0);
        tick();
        n_tests++;
        if (readdata !== 32'h4 || readdata !== m_rd) begin
            n_fail++; $display("FAIL edge_wins: readdata=%h want 4 (model %h)", readdata, m_rd);
        end
    endtask

    task automatic test_partial_clear();
        in_port = 4'hF;
        repeat (25) tick();
        bus_write(2'd3, 32'd0);
        in_port = 4'hA;
        address = 2'd3;
        repeat (25) tick();
        n_tests++;
        if (readdata !== 32'h5) begin n_fail++; $display("FAIL flags_5: readdata=%h want 5", readdata); end
        bus_write(2'd3, 32'h1);
        tick();
        n_tests++;
`ifdef KEY_PIO_BIT_CLEAR_EN
        if (readdata !== 32'h4) begin n_fail++; $display("FAIL bit_clear: readdata=%h want 4", readdata); end
`else
        if (readdata !== 32'h0) begin n_fail++; $display("FAIL clear_all: readdata=%h want 0", readdata); end
`endif
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(14, 40);
            end
            hold--;
            address    = 2'($urandom);
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 5) != 0);
            writedata  = $urandom;
            tick();
            n_tests++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_fail++;
                $display("FAIL random[%0d]: readdata=%h irq=%b want %h/%b", c, readdata, irq, m_rd, m_irq);
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        in_port = 4'hF;
        repeat (25) tick();
        in_port = 4'h0;
        repeat (8) tick();
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: readdata=%h irq=%b want 0/0", readdata, irq);
        end
        in_port = 4'hF;
        tick(); tick();
        reset_n = 1'b1;
        address = 2'd0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_tests++;
            if (readdata !== 32'hF || irq !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_data[%0d]: readdata=%h irq=%b", k, readdata, irq);
            end
        end
        address = 2'd3; tick();
        n_tests++;
        if (readdata !== 32'd0 || readdata !== m_rd) begin
            n_fail++; $display("FAIL post_reset_flags: readdata=%h want 0", readdata);
        end
    endtask

    initial begin
        test_reset();
        test_fall_latency();
        test_irq();
        test_glitch();
        test_edge_vs_clear();
        test_partial_clear();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
